pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch-side owner of the program counter: holds the current PC, presents it to the next-PC adder/mux and receives that mux's PC_new back.
- Issues instruction-memory requests, tracks in-flight fetches and buffers returned instructions for decode over a valid/ready handshake.
- Handles branch/jump redirects by discarding wrong-path fetches.
- Sits between the next-PC mux, instruction memory and decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low two bits must be 0)
DEPTH, 2, max in-flight fetches plus buffered instructions (2..4)

Ports:
CLK  input  1  clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
PC  output  32  current fetch address, drives next-PC mux PC input
PC_new  input  32  next-PC mux output; sequential successor of PC
Redirect  input  1  taken branch/jump from execute; flush wrong path
Redirect_PC  input  32  redirect target
IMem_Req_Valid  output  1  fetch request valid
IMem_Req_Ready  input  1  memory accepts request this cycle
IMem_Addr  output  32  fetch address (= PC)
IMem_Rsp_Valid  input  1  in-order response valid; always accepted, no backpressure
IMem_Rsp_Data  input  32  fetched instruction
Inst_Valid  output  1  instruction available to decode
Inst_Ready  input  1  decode accepts instruction
Inst  output  32  instruction word
Inst_PC  output  32  address of Inst

Behaviour:
- Reset (async, Reset_n=0):
  - PC=RESET_PC.
  - IMem_Req_Valid=0, Inst_Valid=0, Inst=0, Inst_PC=0.
  - FSM=BOOT; in-flight count, drop count and both FIFOs cleared.
- FSM:
  - BOOT: one cycle with no requests, then RUN.
  - RUN: normal operation. No other states.
- Request rules:
  - IMem_Req_Valid = RUN && !Redirect && (inflight + buffered < DEPTH).
  - IMem_Addr = PC, combinational.
  - Withdrawing Req_Valid in a redirect cycle is permitted by the memory contract.
- Request accept (Valid && Ready):
  - PC <= PC_new; push PC into the tag FIFO (depth DEPTH); inflight+1.
  - PC arithmetic stays in the external mux; this block never adds.
- Response:
  - Pop the tag FIFO; inflight-1.
  - If drop count > 0: discard the data and decrement drop count.
  - Otherwise push {IMem_Rsp_Data, tag PC} into the instruction buffer (depth DEPTH).
  - Space is guaranteed by the request rule; overflow is an assertion failure.
- Decode side:
  - Inst/Inst_PC/Inst_Valid come from the buffer head, registered.
  - A response reaches Inst_Valid one cycle after IMem_Rsp_Valid (no bypass).
  - Pop on Inst_Valid && Inst_Ready.
  - Outputs hold stable while Inst_Valid && !Inst_Ready.
- Redirect (priority over request accept):
  - PC <= {Redirect_PC[31:2], 2'b00}.
  - Instruction buffer cleared; Inst_Valid=0 next cycle.
  - drop count <= inflight after this cycle, i.e. every outstanding fetch is dropped, including any already marked.
  - A response arriving in the redirect cycle is discarded.
  - An Inst handshake completing in the redirect cycle stands: decode keeps that instruction.
  - No request is issued in the redirect cycle; the first fetch of the target occurs the next cycle if space allows.
- Simultaneous accept, response and decode pop in one cycle: counters net correctly (+1 and -1).
- inflight + buffered never exceeds DEPTH; a full buffer with Inst_Ready=0 stalls requests indefinitely.
- Reset asserted mid-operation clears all state immediately. Memory is reset with the same Reset_n, so no stale responses arrive.

Test Plan:
- Boot: release Reset_n, Ready=1, memory latency 1, Inst_Ready=1, PC_new=PC+4 -> first IMem_Addr=0x0 on the 2nd cycle after release; Inst_PC sequence 0x0, 0x4, 0x8; Inst matches memory contents.
- Backpressure: Inst_Ready=0 from start, DEPTH=2 -> exactly 2 requests (0x0, 0x4), then Req_Valid=0; Inst=mem[0x0] held stable; Ready=1 resumes with 0x8.
- Redirect with in-flight fetches: 2 outstanding, Redirect=1, Redirect_PC=0x103 -> next IMem_Addr=0x100; both late responses dropped; first Inst_PC after the redirect = 0x100.
- Redirect with same-cycle response and Inst handshake: instruction at 0x4 handed off in the redirect cycle is kept; the response arriving that cycle never appears on Inst.
- Memory stall: IMem_Req_Ready=0 for 5 cycles -> IMem_Addr constant, PC unchanged, no spurious Inst_Valid.
- Async reset mid-stream: Reset_n low between clock edges -> outputs zero immediately, PC=RESET_PC; restart matches the Boot scenario.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-side owner of the program counter: issues instruction fetches, tags them
// with their PC, buffers returned instructions for decode and flushes on redirect.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch requests issued
// RUN   | normal fetch operation
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        Reset_n,
  output logic [31:0] PC,
  input  logic [31:0] PC_new,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req_Valid,
  input  logic        IMem_Req_Ready,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Rsp_Valid,
  input  logic [31:0] IMem_Rsp_Data,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  output logic [31:0] Inst,
  output logic [31:0] Inst_PC
);
  localparam int            AW      = (DEPTH > 2) ? 2 : 1;
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   tag_pc [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] buffered;
  logic [31:0]   ib_data [DEPTH];
  logic [31:0]   ib_pc [DEPTH];
  logic [31:0]   ib_data_n [DEPTH];
  logic [31:0]   ib_pc_n [DEPTH];
  logic [CW:0]   occupancy;
  logic [CW-1:0] wr_idx;
  logic          accept;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign occupancy      = {1'b0, inflight} + {1'b0, buffered};
  assign IMem_Req_Valid = (state == RUN) && !Redirect && (occupancy < {1'b0, DEPTH_C});
  assign IMem_Addr      = pc;
  assign PC             = pc;
  assign accept         = IMem_Req_Valid && IMem_Req_Ready;
  assign pop            = Inst_Valid && Inst_Ready;
  assign push           = IMem_Rsp_Valid && (drop == '0) && !Redirect;
  assign wr_idx         = buffered - CW'(pop);

  // Decode sees the head slot of a shift buffer, so outputs come straight from flops.
  assign Inst_Valid = (buffered != '0);
  assign Inst       = ib_data[0];
  assign Inst_PC    = ib_pc[0];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ib_data_n[i] = ib_data[i];
      ib_pc_n[i]   = ib_pc[i];
      if (pop && (i + 1 < DEPTH)) begin
        ib_data_n[i] = ib_data[(i + 1) % DEPTH];
        ib_pc_n[i]   = ib_pc[(i + 1) % DEPTH];
      end
      if (push && (wr_idx == CW'(i))) begin
        ib_data_n[i] = IMem_Rsp_Data;
        ib_pc_n[i]   = tag_pc[tag_rd];
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      tag_pc   <= '{default: '0};
      tag_wr   <= '0;
      tag_rd   <= '0;
      inflight <= '0;
      drop     <= '0;
      buffered <= '0;
      ib_data  <= '{default: '0};
      ib_pc    <= '{default: '0};
    end else begin
      if (state == BOOT) state <= RUN;

      if (Redirect)    pc <= {Redirect_PC[31:2], 2'b00};
      else if (accept) pc <= PC_new;

      if (accept) begin
        tag_pc[tag_wr] <= pc;
        tag_wr         <= ptr_inc(tag_wr);
      end
      if (IMem_Rsp_Valid) tag_rd <= ptr_inc(tag_rd);
      inflight <= inflight + CW'(accept) - CW'(IMem_Rsp_Valid);

      // Every fetch still outstanding after a redirect belongs to the wrong path.
      if (Redirect)                            drop <= inflight - CW'(IMem_Rsp_Valid);
      else if (IMem_Rsp_Valid && drop != '0)   drop <= drop - CW'(1);

      ib_data <= ib_data_n;
      ib_pc   <= ib_pc_n;
      if (Redirect) buffered <= '0;
      else          buffered <= buffered + CW'(push) - CW'(pop);
    end
  end

  always @(posedge CLK) begin
    if (Reset_n) begin
      assert (!(IMem_Rsp_Valid && inflight == '0));
      assert (!(push && !pop && buffered == DEPTH_C));
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a queue-level model of fetch/drop/buffer behaviour
// checked every cycle, plus directed scenarios pinned with literal values.
module tb_pc_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [31:0] PC;
  logic [31:0] PC_new;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        IMem_Req_Valid;
  logic        IMem_Req_Ready;
  logic [31:0] IMem_Addr;
  logic        IMem_Rsp_Valid;
  logic [31:0] IMem_Rsp_Data;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Inst;
  logic [31:0] Inst_PC;

  logic [31:0] stride = 32'd4;
  assign PC_new = PC + stride;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .PC(PC), .PC_new(PC_new),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .IMem_Req_Valid(IMem_Req_Valid), .IMem_Req_Ready(IMem_Req_Ready), .IMem_Addr(IMem_Addr),
    .IMem_Rsp_Valid(IMem_Rsp_Valid), .IMem_Rsp_Data(IMem_Rsp_Data),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst(Inst), .Inst_PC(Inst_PC)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hDEAD_0000 | {16'h0000, a[15:0]};
  endfunction

  // Instruction memory: in-order responses after a fixed latency, optional hold.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;
  bit    mem_hold = 1'b0;

  // Reference model: outstanding fetches (with wrong-path flag) and decode queue.
  typedef struct { logic [31:0] pc; bit dead; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  fl_t         m_inf[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_run = 1'b0;
  bit          m_req;
  logic [31:0] req_log[$];
  ent_t        dec_log[$];

  always @(posedge CLK) begin
    cyc++;
    if (!Reset_n) begin
      m_inf.delete();
      m_buf.delete();
      mq.delete();
      m_pc  = RESET_PC;
      m_run = 1'b0;
    end else begin
      if (IMem_Rsp_Valid && mq.size() > 0) mq.delete(0);
      if (IMem_Req_Valid && IMem_Req_Ready) begin
        mq.push_back('{IMem_Addr, cyc + lat - 1});
        req_log.push_back(IMem_Addr);
      end
      if (Inst_Valid && Inst_Ready) dec_log.push_back('{Inst_PC, Inst});

      m_req = m_run && !Redirect && (m_inf.size() + m_buf.size() < DEPTH);
      if (m_buf.size() > 0 && Inst_Ready) m_buf.delete(0);
      if (IMem_Rsp_Valid) begin
        if (m_inf.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL model_sync: response arrived with no fetch expected in flight");
        end else begin
          if (!m_inf[0].dead && !Redirect) m_buf.push_back('{m_inf[0].pc, IMem_Rsp_Data});
          m_inf.delete(0);
        end
      end
      if (Redirect) begin
        m_buf.delete();
        foreach (m_inf[i]) m_inf[i].dead = 1'b1;
        m_pc = {Redirect_PC[31:2], 2'b00};
      end else if (m_req && IMem_Req_Ready) begin
        m_inf.push_back('{m_pc, 1'b0});
        m_pc = m_pc + stride;
      end
      m_run = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (!Reset_n) begin
      chk("rst_pc", PC, RESET_PC);
      chk("rst_req_valid", 32'(IMem_Req_Valid), 32'd0);
      chk("rst_inst_valid", 32'(Inst_Valid), 32'd0);
      chk("rst_inst", Inst, 32'd0);
      chk("rst_inst_pc", Inst_PC, 32'd0);
    end else begin
      chk("req_valid", 32'(IMem_Req_Valid),
          32'(m_run && !Redirect && (m_inf.size() + m_buf.size() < DEPTH)));
      chk("pc", PC, m_pc);
      chk("imem_addr", IMem_Addr, m_pc);
      chk("inst_valid", 32'(Inst_Valid), 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        chk("inst", Inst, m_buf[0].data);
        chk("inst_pc", Inst_PC, m_buf[0].pc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
      if (Reset_n && !mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
        IMem_Rsp_Valid = 1'b1;
        IMem_Rsp_Data  = memword(mq[0].addr);
      end else begin
        IMem_Rsp_Valid = 1'b0;
        IMem_Rsp_Data  = 32'h0BAD_F00D;
      end
    end
  endtask

  // Leaves the bench in cycle 0: the first (BOOT) cycle after release.
  task automatic do_reset();
    Reset_n        = 1'b0;
    Redirect       = 1'b0;
    IMem_Rsp_Valid = 1'b0;
    tick(2);
    req_log.delete();
    dec_log.delete();
    Reset_n = 1'b1;
  endtask

  task automatic chk_dec(input string name, input int idx, input logic [31:0] pc,
                         input logic [31:0] data);
    if (idx >= dec_log.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d instructions delivered, expected more than %0d",
               name, dec_log.size(), idx);
    end else begin
      chk({name, "_pc"}, dec_log[idx].pc, pc);
      chk({name, "_data"}, dec_log[idx].data, data);
    end
  endtask

  task automatic chk_req(input string name, input int idx, input logic [31:0] addr);
    if (idx >= req_log.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d requests issued, expected more than %0d",
               name, req_log.size(), idx);
    end else begin
      chk(name, req_log[idx], addr);
    end
  endtask

  task automatic boot_check(input string tag);
    Inst_Ready     = 1'b1;
    IMem_Req_Ready = 1'b1;
    stride         = 32'd4;
    lat            = 1;
    mem_hold       = 1'b0;
    do_reset();
    #1 chk({tag, "_boot_idle"}, 32'(IMem_Req_Valid), 32'd0);
    tick(1);
    #1;
    chk({tag, "_first_req"}, 32'(IMem_Req_Valid), 32'd1);
    chk({tag, "_first_addr"}, IMem_Addr, 32'h0000_0000);
    tick(12);
    chk_dec({tag, "_i0"}, 0, 32'h0000_0000, 32'hDEAD_0000);
    chk_dec({tag, "_i1"}, 1, 32'h0000_0004, 32'hDEAD_0004);
    chk_dec({tag, "_i2"}, 2, 32'h0000_0008, 32'hDEAD_0008);
  endtask

  logic [31:0] saved_pc;
  logic [31:0] rdy_pat = 32'hB5F3_9A6C;
  logic [31:0] ird_pat = 32'h6DB7_3C9F;

  initial begin
    Reset_n        = 1'b0;
    Redirect       = 1'b0;
    Redirect_PC    = 32'h0;
    IMem_Req_Ready = 1'b1;
    IMem_Rsp_Valid = 1'b0;
    IMem_Rsp_Data  = 32'h0;
    Inst_Ready     = 1'b1;

    boot_check("boot");

    // Decode backpressure from the start: buffer fills, requests stop.
    Inst_Ready = 1'b0;
    do_reset();
    tick(10);
    chk("bp_req_count", 32'(req_log.size()), 32'd2);
    chk_req("bp_req0", 0, 32'h0000_0000);
    chk_req("bp_req1", 1, 32'h0000_0004);
    #1;
    chk("bp_stalled", 32'(IMem_Req_Valid), 32'd0);
    chk("bp_head_valid", 32'(Inst_Valid), 32'd1);
    chk("bp_head_inst", Inst, 32'hDEAD_0000);
    Inst_Ready = 1'b1;
    tick(6);
    chk_req("bp_resume", 2, 32'h0000_0008);

    // Memory not ready: address and PC frozen once the pipe drains.
    IMem_Req_Ready = 1'b0;
    tick(4);
    saved_pc = m_pc;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      #1;
      chk("stall_pc", PC, saved_pc);
      chk("stall_addr", IMem_Addr, saved_pc);
      chk("stall_no_inst", 32'(Inst_Valid), 32'd0);
    end
    IMem_Req_Ready = 1'b1;
    stride         = 32'd8;
    tick(10);
    stride = 32'd4;

    // Redirect with two fetches outstanding; both late responses are dropped.
    Inst_Ready = 1'b1;
    mem_hold   = 1'b1;
    do_reset();
    tick(3);
    chk("rd_outstanding", 32'(req_log.size()), 32'd2);
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0103;
    #1 chk("rd_no_req", 32'(IMem_Req_Valid), 32'd0);
    tick(1);
    Redirect = 1'b0;
    #1;
    chk("rd_target_addr", IMem_Addr, 32'h0000_0100);
    chk("rd_target_pc", PC, 32'h0000_0100);
    mem_hold = 1'b0;
    dec_log.delete();
    tick(12);
    chk_dec("rd_first", 0, 32'h0000_0100, 32'hDEAD_0100);
    chk_dec("rd_second", 1, 32'h0000_0104, 32'hDEAD_0104);

    // Redirect in the same cycle as a response for 0x8 and a handoff of 0x4.
    Inst_Ready = 1'b0;
    do_reset();
    tick(4);
    Inst_Ready = 1'b1;
    tick(1);
    Inst_Ready = 1'b0;
    tick(1);
    Inst_Ready  = 1'b1;
    Redirect    = 1'b1;
    Redirect_PC = 32'h0000_0200;
    #1;
    chk("sc_head_valid", 32'(Inst_Valid), 32'd1);
    chk("sc_head_pc", Inst_PC, 32'h0000_0004);
    chk("sc_no_req", 32'(IMem_Req_Valid), 32'd0);
    tick(1);
    Redirect = 1'b0;
    #1;
    chk("sc_flushed", 32'(Inst_Valid), 32'd0);
    chk("sc_target_req", 32'(IMem_Req_Valid), 32'd1);
    chk("sc_target_addr", IMem_Addr, 32'h0000_0200);
    tick(8);
    chk_dec("sc_d0", 0, 32'h0000_0000, 32'hDEAD_0000);
    chk_dec("sc_d1", 1, 32'h0000_0004, 32'hDEAD_0004);
    chk_dec("sc_d2", 2, 32'h0000_0200, 32'hDEAD_0200);

    // Async reset between edges, then a clean restart.
    tick(3);
    #1 Reset_n = 1'b0;
    #1;
    chk("ar_pc", PC, RESET_PC);
    chk("ar_req_valid", 32'(IMem_Req_Valid), 32'd0);
    chk("ar_inst_valid", 32'(Inst_Valid), 32'd0);
    chk("ar_inst", Inst, 32'd0);
    chk("ar_inst_pc", Inst_PC, 32'd0);
    IMem_Rsp_Valid = 1'b0;
    boot_check("restart");

    // Mixed pattern with latency 2 and periodic redirects, model-checked.
    lat = 2;
    do_reset();
    for (int c = 0; c < 120; c++) begin
      IMem_Req_Ready = rdy_pat[c % 32];
      Inst_Ready     = ird_pat[(c * 7) % 32];
      if (c % 17 == 9) begin
        Redirect    = 1'b1;
        Redirect_PC = 32'(32'h400 + c * 8 + 1);
      end else begin
        Redirect = 1'b0;
      end
      tick(1);
    end
    Redirect       = 1'b0;
    Inst_Ready     = 1'b1;
    IMem_Req_Ready = 1'b1;
    tick(10);
    chk("pattern_progress", 32'(dec_log.size() > 10), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1);
  end
endmodule
